cle_sram_sched: RTL and testbench

//  Scheduler for the single-port label SRAM (1024 x 8) behind the connected-component labeling engine.

---
 rtl/cle_sram_sched.sv | 197 +++++++++++++++++++
 tb/tb_cle_sram_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cle_sram_sched.sv
// Single-port label SRAM scheduler: locked/round-robin arbitration of R0/R1 plus a zero-fill clear sequencer.
// Grants are combinational, SRAM pins are registered, and read data returns two cycles after grant; requesters wait while not granted.
module cle_sram_sched #(
    parameter int AW    = 10,
    parameter int DW    = 8,
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    input  logic          r0_req,
    input  logic          r0_lock,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    input  logic          r1_req,
    input  logic          r1_lock,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          rd_valid,
    output logic          rd_id,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    output logic          sram_wen,
    input  logic [DW-1:0] sram_q
);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] CNT_ONE  = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] sram_a_q, sram_a_d;
    logic [DW-1:0] sram_d_q, sram_d_d;
    logic          sram_wen_q, sram_wen_d;
    logic          clr_busy_q, clr_busy_d;
    logic          clr_done_q, clr_done_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          lock_vld_q, lock_vld_d;
    logic          lock_id_q, lock_id_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_pend_id_q, rd_pend_id_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_id_q, rd_id_d;

    logic          owner_req;
    logic          lock_hit;
    logic          arb_en;
    logic          gnt_vld;
    logic          gnt_id;
    logic          sel_we;
    logic          sel_lock;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Arbitration: a live lock beats round-robin; the pointer only moves on contention.
    always_comb begin
        owner_req = lock_id_q ? r1_req : r0_req;
        lock_hit  = lock_vld_q & owner_req;
        arb_en    = (state_q == ST_ARB) & ~clr_start;
        gnt_vld   = 1'b0;
        gnt_id    = 1'b0;
        rr_ptr_d  = rr_ptr_q;
        if (arb_en) begin
            if (lock_hit) begin
                gnt_vld = 1'b1;
                gnt_id  = lock_id_q;
            end else if (r0_req && r1_req) begin
                gnt_vld  = 1'b1;
                gnt_id   = rr_ptr_q;
                rr_ptr_d = ~rr_ptr_q;
            end else if (r0_req) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b0;
            end else if (r1_req) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
        end
        sel_we    = gnt_id ? r1_we    : r0_we;
        sel_lock  = gnt_id ? r1_lock  : r0_lock;
        sel_addr  = gnt_id ? r1_addr  : r0_addr;
        sel_wdata = gnt_id ? r1_wdata : r0_wdata;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sram_a_d   = sram_a_q;
        sram_d_d   = sram_d_q;
        sram_wen_d = 1'b1;
        clr_busy_d = clr_busy_q;
        clr_done_d = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (clr_start) begin
                    state_d    = ST_CLEAR;
                    cnt_d      = '0;
                    sram_a_d   = '0;
                    sram_d_d   = '0;
                    sram_wen_d = 1'b0;
                    clr_busy_d = 1'b1;
                end else if (gnt_vld) begin
                    sram_a_d   = sel_addr;
                    sram_d_d   = sel_wdata;
                    sram_wen_d = ~sel_we;
                end
            end
            ST_CLEAR: begin
                // The pins already show address cnt_q; stop once the last word is on them.
                if (cnt_q == CNT_LAST) begin
                    state_d    = ST_ARB;
                    clr_busy_d = 1'b0;
                    clr_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CNT_ONE;
                    sram_a_d   = cnt_q + CNT_ONE;
                    sram_d_d   = '0;
                    sram_wen_d = 1'b0;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        if (gnt_vld) begin
            lock_vld_d = sel_lock;
            lock_id_d  = gnt_id;
        end else if (lock_vld_q && !owner_req) begin
            lock_vld_d = 1'b0;
        end
        rd_pend_d    = gnt_vld & ~sel_we;
        rd_pend_id_d = gnt_id;
        rd_valid_d   = rd_pend_q;
        rd_id_d      = rd_pend_q ? rd_pend_id_q : rd_id_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ARB;
            cnt_q        <= '0;
            sram_a_q     <= '0;
            sram_d_q     <= '0;
            sram_wen_q   <= 1'b1;
            clr_busy_q   <= 1'b0;
            clr_done_q   <= 1'b0;
            rr_ptr_q     <= 1'b0;
            lock_vld_q   <= 1'b0;
            lock_id_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_pend_id_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_id_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sram_a_q     <= sram_a_d;
            sram_d_q     <= sram_d_d;
            sram_wen_q   <= sram_wen_d;
            clr_busy_q   <= clr_busy_d;
            clr_done_q   <= clr_done_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_vld_q   <= lock_vld_d;
            lock_id_q    <= lock_id_d;
            rd_pend_q    <= rd_pend_d;
            rd_pend_id_q <= rd_pend_id_d;
            rd_valid_q   <= rd_valid_d;
            rd_id_q      <= rd_id_d;
        end
    end

    assign r0_gnt   = gnt_vld & ~gnt_id;
    assign r1_gnt   = gnt_vld & gnt_id;
    assign sram_a   = sram_a_q;
    assign sram_d   = sram_d_q;
    assign sram_wen = sram_wen_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;
    assign rd_valid = rd_valid_q;
    assign rd_id    = rd_id_q;
    assign rd_data  = rd_valid_q ? sram_q : '0;

endmodule

// File: tb/tb_cle_sram_sched.sv
// Bench for cle_sram_sched: SRAM model, cycle-level reference model and directed scenarios.
module tb_cle_sram_sched;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          clr_start, clr_busy, clr_done;
    logic          r0_req, r0_lock, r0_we, r0_gnt;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r1_req, r1_lock, r1_we, r1_gnt;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          rd_valid, rd_id;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic          sram_wen;
    logic [DW-1:0] sram_q;

    cle_sram_sched #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .r0_req(r0_req), .r0_lock(r0_lock), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_gnt(r0_gnt),
        .r1_req(r1_req), .r1_lock(r1_lock), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt),
        .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
        .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen), .sram_q(sram_q)
    );

    always #5 clk = ~clk;

    // Single-port SRAM: writes on the edge, read data appears the cycle after the address is sampled.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (!sram_wen) mem[sram_a] <= sram_d;
        else           sram_q <= mem[sram_a];
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: whole-cycle view of who owns the port and what the pins must show.
    int  cyc = 0;
    bit  m_clear, m_lock_vld, m_lock_id, m_rr;
    int  m_idx;
    int  e_a, e_d, e_wen, e_busy, e_done;
    int  mem_m [0:DEPTH-1];
    int  due_id [int];
    int  due_dat [int];

    function automatic int m_pick();
        bit rq [2];
        rq[0] = r0_req;
        rq[1] = r1_req;
        if (m_clear || clr_start) return -1;
        if (m_lock_vld && rq[m_lock_id]) return int'(m_lock_id);
        if (rq[0] && rq[1]) return int'(m_rr);
        if (rq[0]) return 0;
        if (rq[1]) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int  g;
        bit  rq [2];
        bit  lockwin;
        rq[0] = r0_req;
        rq[1] = r1_req;
        if (reset) begin
            m_clear = 0; m_idx = 0; m_lock_vld = 0; m_lock_id = 0; m_rr = 0;
            e_a = 0; e_d = 0; e_wen = 1; e_busy = 0; e_done = 0;
            due_id.delete();
            due_dat.delete();
        end else begin
            g = m_pick();
            lockwin = m_lock_vld && rq[m_lock_id];
            e_done = 0;
            e_wen = 1;
            if (m_clear) begin
                if (m_idx == DEPTH - 1) begin
                    m_clear = 0; e_busy = 0; e_done = 1;
                end else begin
                    m_idx++;
                    e_a = m_idx; e_d = 0; e_wen = 0; mem_m[m_idx] = 0;
                end
            end else if (clr_start) begin
                m_clear = 1; m_idx = 0; e_busy = 1;
                e_a = 0; e_d = 0; e_wen = 0; mem_m[0] = 0;
            end else if (g >= 0) begin
                e_a   = (g == 0) ? int'(r0_addr)  : int'(r1_addr);
                e_d   = (g == 0) ? int'(r0_wdata) : int'(r1_wdata);
                e_wen = (g == 0) ? int'(!r0_we)   : int'(!r1_we);
                if (e_wen == 0) mem_m[e_a] = e_d;
                else begin
                    due_id[cyc + 2]  = g;
                    due_dat[cyc + 2] = mem_m[e_a];
                end
                m_lock_vld = (g == 0) ? r0_lock : r1_lock;
                m_lock_id  = (g == 1);
                if (!lockwin && rq[0] && rq[1]) m_rr = (g == 0);
            end
            if (g < 0 && m_lock_vld && !rq[m_lock_id]) m_lock_vld = 0;
        end
        cyc++;
    end

    always @(negedge clk) begin
        int g;
        bit rdv;
        if (chk_en) begin
            g = m_pick();
            chk("r0_gnt", 32'(r0_gnt), 32'(g == 0));
            chk("r1_gnt", 32'(r1_gnt), 32'(g == 1));
            chk("sram_a", 32'(sram_a), e_a);
            chk("sram_d", 32'(sram_d), e_d);
            chk("sram_wen", 32'(sram_wen), e_wen);
            chk("clr_busy", 32'(clr_busy), e_busy);
            chk("clr_done", 32'(clr_done), e_done);
            rdv = due_id.exists(cyc);
            chk("rd_valid", 32'(rd_valid), 32'(rdv));
            if (rdv) begin
                chk("rd_id", 32'(rd_id), due_id[cyc]);
                chk("rd_data", 32'(rd_data), due_dat[cyc]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0, busy_n, done_at, first_a, last_a, done_n;
        bit seen;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 8'hA5;
            mem_m[i] = 8'hA5;
        end
        reset = 1; clr_start = 0;
        r0_req = 0; r0_lock = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_lock = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
        repeat (3) step();
        reset = 0;
        chk_en = 1;
        @(negedge clk);
        chk("rst_wen", 32'(sram_wen), 1);
        chk("rst_busy", 32'(clr_busy), 0);
        chk("rst_a", 32'(sram_a), 0);
        chk("rst_rdv", 32'(rd_valid), 0);
        step();

        // Full clear: busy for DEPTH cycles, done pulse one cycle later.
        clr_start = 1;
        @(negedge clk);
        t0 = cyc;
        step();
        clr_start = 0;
        busy_n = 0; done_at = -1; first_a = -1; last_a = -1;
        for (int i = 0; i < 1100 && done_at < 0; i++) begin
            @(negedge clk);
            if (clr_busy) begin
                if (busy_n == 0) first_a = sram_a;
                last_a = sram_a;
                busy_n++;
            end
            if (clr_done) done_at = cyc - t0;
            step();
        end
        chk("t1_done_cycle", done_at, 1025);
        chk("t1_busy_cycles", busy_n, 1024);
        chk("t1_first_addr", first_a, 0);
        chk("t1_last_addr", last_a, 1023);

        // Both requesters reading: strict alternation starting with R0.
        r0_req = 1; r0_addr = 10'd5; r1_req = 1; r1_addr = 10'd9;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) begin r0_req = 0; r1_req = 0; end
            @(negedge clk);
            if (i < 6) begin
                chk("t2_r0_gnt", 32'(r0_gnt), 32'(i % 2 == 0));
                chk("t2_r1_gnt", 32'(r1_gnt), 32'(i % 2 == 1));
            end
            if (i >= 2) begin
                chk("t2_rd_valid", 32'(rd_valid), 1);
                chk("t2_rd_id", 32'(rd_id), (i - 2) % 2);
            end
            step();
        end

        // Locked write burst by R0 holds R1 off until the lock drops.
        r0_req = 1; r0_we = 1; r0_addr = 10'd33; r0_wdata = 8'h07; r0_lock = 1;
        r1_req = 1; r1_we = 0; r1_addr = 10'd33;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) r0_lock = 0;
            if (i == 5) r0_req = 0;
            if (i == 6) r1_req = 0;
            @(negedge clk);
            if (i < 5) begin
                chk("t3_r0_gnt", 32'(r0_gnt), 1);
                chk("t3_r1_gnt", 32'(r1_gnt), 0);
            end else if (i == 5) begin
                chk("t3_r1_gnt_after", 32'(r1_gnt), 1);
            end else if (i == 7) begin
                chk("t3_rd_data", 32'(rd_data), 32'h07);
                chk("t3_rd_id", 32'(rd_id), 1);
            end
            step();
        end
        r0_we = 0;

        // clr_start beats a pending request; R0 waits out the clear.
        r0_req = 1; r0_addr = 10'd33; clr_start = 1;
        @(negedge clk);
        chk("t4_gnt_at_start", 32'(r0_gnt), 0);
        step();
        clr_start = 0;
        seen = 0;
        for (int i = 0; i < 1100 && !seen; i++) begin
            @(negedge clk);
            if (clr_done) begin
                chk("t4_gnt_after_clear", 32'(r0_gnt), 1);
                seen = 1;
            end
            step();
        end
        chk("t4_done_seen", 32'(seen), 1);
        r0_req = 0;
        repeat (3) step();

        // Reset in the middle of a clear, then a fresh clear from address 0.
        clr_start = 1;
        step();
        clr_start = 0;
        repeat (300) step();
        reset = 1;
        @(negedge clk);
        chk("t5_addr_at_reset", 32'(sram_a), 300);
        step();
        reset = 0;
        @(negedge clk);
        chk("t5_wen_after_reset", 32'(sram_wen), 1);
        chk("t5_busy_after_reset", 32'(clr_busy), 0);
        step();
        done_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (clr_done) done_n++;
            step();
        end
        chk("t5_no_done", done_n, 0);
        clr_start = 1;
        step();
        clr_start = 0;
        @(negedge clk);
        chk("t5_restart_addr", 32'(sram_a), 0);
        chk("t5_restart_busy", 32'(clr_busy), 1);
        seen = 0;
        for (int i = 0; i < 1100 && !seen; i++) begin
            @(negedge clk);
            if (clr_done) seen = 1;
            step();
        end
        chk("t5_done_seen", 32'(seen), 1);

        // Write then immediate read of the same address by the other requester.
        r0_req = 1; r0_we = 1; r0_addr = 10'd1023; r0_wdata = 8'h2A;
        step();
        r0_req = 0; r0_we = 0;
        r1_req = 1; r1_we = 0; r1_addr = 10'd1023;
        step();
        r1_req = 0;
        step();
        @(negedge clk);
        chk("t6_rd_valid", 32'(rd_valid), 1);
        chk("t6_rd_id", 32'(rd_id), 1);
        chk("t6_rd_data", 32'(rd_data), 32'h2A);
        repeat (3) step();

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
